// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
// Shared types and constants for the JK flip-flop load controller.
//   state_e     : controller FSM states (IDLE, DRIVE, CHECK)
//   JK_*        : two-bit {J,K} excitation codes
//   excite_bit  : excitation for one bit from its current Q and its target T
// -----------------------------------------------------------------------------
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Returns {J,K} that moves a flip-flop holding q to t in one clock.
    function automatic logic [1:0] excite_bit(
        input logic q,
        input logic t,
        input logic use_toggle
    );
        logic [1:0] jk_s;
        if (q == t) begin
            jk_s = JK_HOLD;
        end else if (use_toggle) begin
            jk_s = JK_TGL;
        end else if (t) begin
            jk_s = JK_SET;
        end else begin
            jk_s = JK_RST;
        end
        return jk_s;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// -----------------------------------------------------------------------------
// jk_excite
// Purely combinational per-bit J/K excitation for a WIDTH-bit JK bank.
// Ports:
//   q : current bank outputs
//   t : target word
//   j : J inputs that move q to t
//   k : K inputs that move q to t
// USE_TOGGLE selects toggle (11) versus explicit set/reset (10/01) for
// differing bits; equal bits always hold (00).
// -----------------------------------------------------------------------------
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int USE_TOGGLE = 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    localparam logic TOGGLE_C = (USE_TOGGLE != 0);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign {j[gi], k[gi]} = excite_bit(q[gi], t[gi], TOGGLE_C);
    end

endmodule

// File: rtl/jk_load_ctrl.sv
// -----------------------------------------------------------------------------
// jk_load_ctrl
// Initiator side of the JK flip-flop interface. Accepts a target word over a
// valid/ready handshake, drives J/K excitation into an external JK bank for one
// cycle, checks the bank against the target and retries up to MAX_RETRY times.
// Ports:
//   clk       : system clock, all logic on posedge
//   rst       : synchronous active-low reset
//   tgt_valid : target word offered
//   tgt_data  : target word
//   tgt_ready : controller can accept a target (IDLE only)
//   q_fb      : current Q outputs of the driven JK bank
//   j, k      : registered J/K inputs to the bank
//   busy      : high in DRIVE and CHECK
//   done      : one-cycle pulse, bank matched the target
//   err       : one-cycle pulse, retries exhausted without a match
// -----------------------------------------------------------------------------
module jk_load_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_RETRY  = 2,
    parameter int USE_TOGGLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int             RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0]  MAX_RETRY_C = RW'(MAX_RETRY);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] tgt_nxt_s;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] j_nxt_s;
    logic [WIDTH-1:0] k_r;
    logic [WIDTH-1:0] k_nxt_s;
    logic [RW-1:0]    retry_cnt_r;
    logic [RW-1:0]    retry_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             err_r;
    logic             err_nxt_s;

    logic [WIDTH-1:0] exc_t_s;
    logic [WIDTH-1:0] exc_j_s;
    logic [WIDTH-1:0] exc_k_s;

    // Single excitation unit: new targets come from the port in IDLE,
    // retries re-use the captured target in CHECK.
    always_comb begin
        if (state_r == CHECK) begin
            exc_t_s = tgt_r;
        end else begin
            exc_t_s = tgt_data;
        end
    end

    jk_excite #(
        .WIDTH      (WIDTH),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_excite (
        .q (q_fb),
        .t (exc_t_s),
        .j (exc_j_s),
        .k (exc_k_s)
    );

    // Next-state and next-output logic; j/k fall back to hold unless loading.
    always_comb begin
        state_nxt_s = state_r;
        tgt_nxt_s   = tgt_r;
        retry_nxt_s = retry_cnt_r;
        j_nxt_s     = {WIDTH{1'b0}};
        k_nxt_s     = {WIDTH{1'b0}};
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_nxt_s   = tgt_data;
                    retry_nxt_s = {RW{1'b0}};
                    j_nxt_s     = exc_j_s;
                    k_nxt_s     = exc_k_s;
                    state_nxt_s = DRIVE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRIVE: begin
                state_nxt_s = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_r) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else if (retry_cnt_r < MAX_RETRY_C) begin
                    retry_nxt_s = retry_cnt_r + RW'(1);
                    j_nxt_s     = exc_j_s;
                    k_nxt_s     = exc_k_s;
                    state_nxt_s = DRIVE;
                end else begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            tgt_r       <= {WIDTH{1'b0}};
            retry_cnt_r <= {RW{1'b0}};
            j_r         <= {WIDTH{1'b0}};
            k_r         <= {WIDTH{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            tgt_r       <= tgt_nxt_s;
            retry_cnt_r <= retry_nxt_s;
            j_r         <= j_nxt_s;
            k_r         <= k_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    assign j         = j_r;
    assign k         = k_r;
    assign done      = done_r;
    assign err       = err_r;
    assign busy      = (state_r == DRIVE) || (state_r == CHECK);
    // Derived from busy so the two can never disagree, even from an unused encoding.
    assign tgt_ready = ~busy;

endmodule

// File: doc/jk_load_ctrl.md
Name: jk_load_ctrl

Overview:
- Initiator/driver side of the team's JK flip-flop interface.
- Accepts a target word over a valid/ready handshake and computes per-bit J/K excitation from the current flip-flop outputs (fed back on q_fb).
- Drives that excitation for one cycle, then checks that the JK bank reached the target. Retries on mismatch; reports done or err.
- Sits in front of any WIDTH-bit bank of JK flip-flops that is used as a loadable register.

Parameters:
- WIDTH, 8: bits in the target word and in the JK bank.
- MAX_RETRY, 2: additional drive attempts after the first failed check (0..7).
- USE_TOGGLE, 1: 1 = differing bits are driven with toggle (11); 0 = differing bits are driven with explicit set (10) or reset (01).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-low reset.
- tgt_valid  in  1  target word offered.
- tgt_data  in  WIDTH  target word.
- tgt_ready  out  1  controller can accept a target (high in IDLE only).
- q_fb  in  WIDTH  current Q outputs of the driven JK bank.
- j  out  WIDTH  J inputs to the bank (registered).
- k  out  WIDTH  K inputs to the bank (registered).
- busy  out  1  high in DRIVE and CHECK.
- done  out  1  one-cycle pulse: bank matched target.
- err  out  1  one-cycle pulse: retries exhausted without a match.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; j=k=0; done=err=busy=0; tgt_r=0; retry_cnt=0.
  - Reset mid-operation abandons the transfer: no done or err is produced, and j/k return to hold (00) at that edge.
- Excitation per bit i, computed from (q, t):
  - q==t gives 00 (hold).
  - q!=t with USE_TOGGLE=1 gives 11.
  - q!=t with USE_TOGGLE=0 gives 10 if t==1, else 01.
- IDLE:
  - tgt_ready=1, j=k=0.
  - On tgt_valid&&tgt_ready: capture tgt_data into tgt_r, set retry_cnt=0, load j/k with excitation(q_fb, tgt_data), go to DRIVE.
- DRIVE (exactly 1 cycle):
  - j/k are presented to the bank, which updates at the end of this cycle.
  - Next edge: j=k=0, go to CHECK.
- CHECK (1 cycle): compare q_fb with tgt_r.
  - Match: done=1 for the next cycle, go to IDLE.
  - Mismatch and retry_cnt<MAX_RETRY: retry_cnt+1, load j/k with excitation(q_fb, tgt_r), go to DRIVE.
  - Mismatch and retry_cnt==MAX_RETRY: err=1 for the next cycle, go to IDLE.
- Latency:
  - Handshake edge E0, DRIVE cycle, CHECK cycle; done/err visible in the cycle after edge E2.
  - Each retry adds 2 cycles.
- done/err are registered and coincide with IDLE, so tgt_ready is already high. A new target may be accepted in the same cycle that done/err is high (back-to-back supported).
- Target equal to the current q_fb: j/k all 00, the full DRIVE/CHECK sequence still runs, done at E0+2.
- tgt_data is ignored outside IDLE. tgt_valid while busy is held off by tgt_ready=0.
- done and err are never high together. busy and tgt_ready are always complementary.
- retry_cnt width is clog2(MAX_RETRY+1), minimum 1.

Decomposition:
- Package jk_pkg:
  - State enum {IDLE, DRIVE, CHECK}.
  - Constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
- Sub-module jk_excite:
  - Purely combinational, parameterised by WIDTH and USE_TOGGLE.
  - Inputs q, t; outputs j, k.
  - Instantiated once; its output is muxed between tgt_data (IDLE) and tgt_r (CHECK).
- The FSM, retry counter and output registers live in jk_load_ctrl.

Test Plan:
- Reset: hold rst=0 for 2 cycles with tgt_valid=1 -> j=k=0, done=err=busy=0, tgt_ready=1; no capture.
- Basic load, WIDTH=8, USE_TOGGLE=1, bank Q=8'h00, target 8'hA5 -> during DRIVE j=k=8'hA5; q_fb=8'hA5 in CHECK; done pulses at E0+2; err stays 0.
- Explicit mode, USE_TOGGLE=0, Q=8'hF0, target 8'h3C -> j=8'h0C, k=8'hC0; done at E0+2.
- Fault and retry, MAX_RETRY=2, bank bit 0 forced stuck at 0, target 8'h01 -> three DRIVE cycles each with j[0]=1; err pulses at E0+6; done never asserts.
- Back-to-back: hold tgt_valid=1 with targets 8'h11 then 8'h22 -> second accept occurs in the done cycle of the first; both done pulses 3 cycles apart.
- Mid-op reset: rst=0 during DRIVE of target 8'hFF -> next cycle j=k=0, state IDLE, no done or err.
